// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI frame receiver: FSM state encoding,
// error_code values and the default command/address bytes.
package spi_frame_pkg;

  typedef enum logic [1:0] {
    WAIT_CMD  = 2'd0,
    WAIT_ADDR = 2'd1,
    PAYLOAD   = 2'd2,
    DRAIN     = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_CMD   = 2'd1;
  localparam logic [1:0] ERR_ADDR  = 2'd2;
  localparam logic [1:0] ERR_SHORT = 2'd3;

  localparam logic [7:0] CMD_WRITE_DEF  = 8'h02;
  localparam logic [7:0] START_ADDR_DEF = 8'h00;

endpackage

// File: rtl/spi_frame_receiver.sv
// Assembles a command + address + payload SPI frame into a wide sensor word
// bus, publishing only complete frames and flagging malformed ones.
module spi_frame_receiver
  import spi_frame_pkg::*;
#(
  parameter int         NUM_SENSORS = 8,
  parameter logic [7:0] CMD_WRITE   = CMD_WRITE_DEF,
  parameter logic [7:0] START_ADDR  = START_ADDR_DEF
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      cs_n,
  input  logic [7:0]                rx_byte,
  input  logic                      rx_valid,
  output logic [32*NUM_SENSORS-1:0] frame_data,
  output logic                      frame_valid,
  output logic                      frame_error,
  output logic [1:0]                error_code,
  output logic [15:0]               frame_count
);

  localparam int PAYLOAD_BYTES = 4 * NUM_SENSORS;
  localparam int CNT_W         = $clog2(PAYLOAD_BYTES + 1);
  localparam int DATA_W        = 32 * NUM_SENSORS;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_BYTES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  staging_q, staging_d;
  logic [DATA_W-1:0]  frame_data_q, frame_data_d;
  logic               frame_valid_q, frame_valid_d;
  logic               frame_error_q, frame_error_d;
  logic [1:0]         error_code_q, error_code_d;
  logic [15:0]        frame_count_q, frame_count_d;

  // Deasserted chip select wins over any byte arriving in the same cycle.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    staging_d     = staging_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    frame_error_d = 1'b0;
    error_code_d  = error_code_q;
    frame_count_d = frame_count_q;

    if (cs_n) begin
      state_d   = WAIT_CMD;
      cnt_d     = '0;
      staging_d = '0;
      if (state_q == WAIT_ADDR || state_q == PAYLOAD) begin
        frame_error_d = 1'b1;
        error_code_d  = ERR_SHORT;
      end
    end else if (rx_valid) begin
      case (state_q)
        WAIT_CMD: begin
          if (rx_byte == CMD_WRITE) begin
            state_d = WAIT_ADDR;
          end else begin
            state_d       = DRAIN;
            frame_error_d = 1'b1;
            error_code_d  = ERR_CMD;
          end
        end
        WAIT_ADDR: begin
          if (rx_byte == START_ADDR) begin
            state_d = PAYLOAD;
            cnt_d   = '0;
          end else begin
            state_d       = DRAIN;
            frame_error_d = 1'b1;
            error_code_d  = ERR_ADDR;
          end
        end
        PAYLOAD: begin
          for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            if (cnt_q == CNT_W'(i)) staging_d[8*i +: 8] = rx_byte;
          end
          cnt_d = cnt_q + CNT_W'(1);
          // The published copy includes the byte arriving this cycle.
          if (cnt_q == LAST_IDX) begin
            frame_data_d  = staging_d;
            frame_valid_d = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            state_d       = DRAIN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= WAIT_CMD;
      cnt_q         <= '0;
      staging_q     <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      error_code_q  <= ERR_NONE;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      staging_q     <= staging_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      error_code_q  <= error_code_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_error = frame_error_q;
  assign error_code  = error_code_q;
  assign frame_count = frame_count_q;

endmodule
